// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation codes,
// default latencies, FSM state type and small op-classification helpers.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;
  localparam int MDU_CNT_W       = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_long_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational MDU arithmetic: 64-bit products and 32-bit quotient/remainder
// from the latched operands, packed as {hi, lo}, plus a divide-by-zero flag.
module e_mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_res,
  output logic        o_div0
);

  logic signed [63:0] w_sa64;
  logic signed [63:0] w_sb64;
  logic signed [63:0] w_sprod;
  logic        [63:0] w_uprod;
  logic        [31:0] w_b_safe;
  logic        [31:0] w_sq;
  logic        [31:0] w_sr;
  logic        [31:0] w_uq;
  logic        [31:0] w_ur;

  // Signed division with the one overflowing case pinned to the architectural answer.
  function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'sh8000_0000;
      r = 32'sd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  assign w_sa64   = {{32{i_a[31]}}, i_a};
  assign w_sb64   = {{32{i_b[31]}}, i_b};
  assign w_sprod  = w_sa64 * w_sb64;
  assign w_uprod  = {32'd0, i_a} * {32'd0, i_b};
  // A zero divisor is replaced so the dividers never see it; the flag suppresses the commit.
  assign w_b_safe = (i_b == 32'd0) ? 32'd1 : i_b;
  assign {w_sr, w_sq} = sdiv(i_a, w_b_safe);
  assign w_uq     = i_a / w_b_safe;
  assign w_ur     = i_a % w_b_safe;
  assign o_div0   = (i_b == 32'd0) && ((i_op == OP_DIV) || (i_op == OP_DIVU));

  always_comb begin
    o_res = 64'd0;
    case (i_op)
      OP_MULT:  o_res = w_sprod;
      OP_MULTU: o_res = w_uprod;
      OP_DIV:   o_res = {w_sr, w_sq};
      OP_DIVU:  o_res = {w_ur, w_uq};
      default:  o_res = 64'd0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: IDLE/RUN FSM with a latency counter, operand
// latch and the architectural HI/LO registers; arithmetic lives in e_mdu_calc.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        req_flush,
  output logic        busy,
  output logic        mdu_stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  mdu_state_e           r_state;
  mdu_state_e           w_state_nxt;
  logic [MDU_CNT_W-1:0] r_cnt;
  logic [MDU_CNT_W-1:0] w_cnt_nxt;
  logic [31:0]          r_hi;
  logic [31:0]          r_lo;
  logic [31:0]          w_hi_nxt;
  logic [31:0]          w_lo_nxt;
  logic [31:0]          r_a;
  logic [31:0]          r_b;
  logic [2:0]           r_op;
  logic                 w_accept;
  logic                 w_latch;
  logic [63:0]          w_res;
  logic                 w_div0;

  e_mdu_calc u_calc (
    .i_op   (r_op),
    .i_a    (r_a),
    .i_b    (r_b),
    .o_res  (w_res),
    .o_div0 (w_div0)
  );

  assign w_accept  = start && !req_flush && (r_state == ST_IDLE);
  assign busy      = (r_state == ST_RUN);
  assign mdu_stall = busy || (start && is_long_op(mdu_op));
  assign hi_out    = r_hi;
  assign lo_out    = r_lo;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_long_op(mdu_op)) begin
            w_state_nxt = ST_RUN;
            w_latch     = 1'b1;
            w_cnt_nxt   = is_mult_op(mdu_op) ? MDU_CNT_W'(MULT_CYCLES)
                                             : MDU_CNT_W'(DIV_CYCLES);
          end else if (mdu_op == OP_MTHI) begin
            w_hi_nxt = rs_val;
          end else if (mdu_op == OP_MTLO) begin
            w_lo_nxt = rs_val;
          end
        end
      end
      ST_RUN: begin
        w_cnt_nxt = r_cnt - 1'b1;
        // Last busy cycle: commit on this edge unless the divisor was zero.
        if (r_cnt <= MDU_CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          if (!w_div0) begin
            w_hi_nxt = w_res[63:32];
            w_lo_nxt = w_res[31:0];
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  // Operand latch carries no reset: it is only read while in RUN.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_a  <= rs_val;
      r_b  <= rt_val;
      r_op <= mdu_op;
    end
  end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, meaning the busy cycles for mult/multu.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, meaning the busy cycles for div/divu.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, the E-stage instruction is an MDU operation.
REQ-006 The block SHALL have port mdu_op, input, 3, the operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
REQ-007 The block SHALL have port rs_val, input, 32, the forwarded rs operand.
REQ-008 The block SHALL have port rt_val, input, 32, the forwarded rt operand.
REQ-009 The block SHALL have port req_flush, input, 1, an exception/interrupt this cycle; it cancels a same-cycle start.
REQ-010 The block SHALL have port busy, output, 1, an operation is in flight (registered).
REQ-011 The block SHALL have port mdu_stall, output, 1, equal to busy OR (start AND mdu_op in 1..4), for the D-stage stall logic.
REQ-012 The block SHALL have port hi_out, output, 32, the committed HI register.
REQ-013 The block SHALL have port lo_out, output, 32, the committed LO register.

Function
REQ-014 A start is accepted only when start=1, req_flush=0 and busy=0; otherwise it SHALL be ignored with no state change.
REQ-015 The FSM SHALL have states IDLE and RUN; IDLE->RUN on an accepted op 1..4; RUN->IDLE when the counter reaches 1.
REQ-016 On acceptance the operands and op SHALL be latched, and the counter SHALL load MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
REQ-017 In RUN the counter SHALL decrement each cycle; busy=1 for exactly the loaded count of cycles starting the cycle after acceptance.
REQ-018 HI/LO SHALL be written on the final RUN edge; hi_out/lo_out SHALL show the old values until then.
REQ-019 mult SHALL compute the signed 64-bit product and multu the unsigned 64-bit product, with HI=[63:32] and LO=[31:0].
REQ-020 div/divu SHALL set LO=quotient (truncated toward zero) and HI=remainder (sign follows the dividend), signed and unsigned respectively.
REQ-021 For signed 0x80000000 / 0xFFFFFFFF the block SHALL write LO=0x80000000 and HI=0.
REQ-022 For divide-by-zero (rt_val=0) HI and LO SHALL remain unchanged; the busy timing is unaffected.
REQ-023 mthi/mtlo, when accepted, SHALL write rs_val to HI/LO at the next edge with no busy cycles.
REQ-024 req_flush SHALL NOT abort an operation already in RUN; it completes and commits.
REQ-025 Op 0 or codes 7 with start=1 SHALL be ignored.

Reset
REQ-026 When reset=0 the block SHALL immediately enter IDLE, with counter=0, busy=0, hi_out=0 and lo_out=0, including mid-operation; the in-flight result SHALL be discarded.
REQ-027 After reset deasserts, the first accepted start SHALL behave as from power-up.

Structure
REQ-028 The mdu_op encodings and the default MULT_CYCLES/DIV_CYCLES SHALL reside in the shared package mdu_pkg.
REQ-029 The arithmetic SHALL be one combinational sub-module, e_mdu_calc (latched operands and op in, 64-bit {hi,lo} result plus a div-by-zero flag out); the FSM and registers SHALL stay in e_mdu.

Verification
REQ-030 The bench SHALL cover: mult with rs=0xFFFFFFFE, rt=3 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 The bench SHALL cover: multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-032 The bench SHALL cover: div rs=-7, rt=2 -> 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; and divu rs=7, rt=0 -> HI/LO unchanged.
REQ-033 The bench SHALL cover: a start during busy, and a start with req_flush=1 -> ignored, with the results and timing of the first op intact.
REQ-034 The bench SHALL cover: mthi 0x12345678 -> hi_out=0x12345678 next cycle, with busy staying 0.
REQ-035 The bench SHALL cover: reset pulled low at cycle 3 of a div -> busy=0 and HI=LO=0 immediately; a following mult completes normally.
